// File: rtl/jump_pkg.sv
// Shared types for the FU_jump issue controller: op codes, FSM states and queue entry layouts.
package jump_pkg;

    localparam int JUMP_XLEN  = 32;
    localparam int JUMP_TAG_W = 3;

    localparam logic [1:0] JOP_BR   = 2'b00;
    localparam logic [1:0] JOP_JAL  = 2'b01;
    localparam logic [1:0] JOP_JALR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_WB      = 2'd3
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            op;
        logic [2:0]            cmp_ctrl;
        logic [JUMP_XLEN-1:0]  rs1_val;
        logic                  rs1_rdy;
        logic [JUMP_TAG_W-1:0] rs1_tag;
        logic [JUMP_XLEN-1:0]  rs2_val;
        logic                  rs2_rdy;
        logic [JUMP_TAG_W-1:0] rs2_tag;
        logic [JUMP_XLEN-1:0]  imm;
        logic [JUMP_XLEN-1:0]  pc;
        logic [JUMP_TAG_W-1:0] rd_tag;
    } entry_t;

    // The slice of an entry the issue/resolve path needs once operands are in.
    typedef struct packed {
        logic [1:0]            op;
        logic [2:0]            cmp_ctrl;
        logic [JUMP_XLEN-1:0]  rs1_val;
        logic [JUMP_XLEN-1:0]  rs2_val;
        logic [JUMP_XLEN-1:0]  imm;
        logic [JUMP_XLEN-1:0]  pc;
        logic [JUMP_TAG_W-1:0] rd_tag;
    } issue_t;

endpackage

// File: rtl/jump_rs_entry.sv
// One reservation-queue slot: write port, clear, and CDB snoop that also covers
// the same-cycle dispatch bypass (the snoop runs on the post-write value).
module jump_rs_entry
    import jump_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  entry_t                wr_entry_i,
    input  logic                  clr_i,
    input  logic                  cdb_valid_i,
    input  logic [JUMP_TAG_W-1:0] cdb_tag_i,
    input  logic [JUMP_XLEN-1:0]  cdb_data_i,
    output logic                  ready_o,
    output issue_t                issue_o
);

    entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (clr_i) begin
            entry_d = '0;
        end else if (wr_en_i) begin
            entry_d = wr_entry_i;
        end
        if (entry_d.valid && !entry_d.rs1_rdy && cdb_valid_i && (cdb_tag_i == entry_d.rs1_tag)) begin
            entry_d.rs1_val = cdb_data_i;
            entry_d.rs1_rdy = 1'b1;
        end
        if (entry_d.valid && !entry_d.rs2_rdy && cdb_valid_i && (cdb_tag_i == entry_d.rs2_tag)) begin
            entry_d.rs2_val = cdb_data_i;
            entry_d.rs2_rdy = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign ready_o = entry_q.valid & entry_q.rs1_rdy & entry_q.rs2_rdy;

    assign issue_o = '{
        op:       entry_q.op,
        cmp_ctrl: entry_q.cmp_ctrl,
        rs1_val:  entry_q.rs1_val,
        rs2_val:  entry_q.rs2_val,
        imm:      entry_q.imm,
        pc:       entry_q.pc,
        rd_tag:   entry_q.rd_tag
    };

endmodule

// File: rtl/jump_ctrl.sv
// In-order issue controller for the single FU_jump: reservation queue, issue FSM,
// PC redirect/flush and link writeback arbitration. Handshakes: dispatch pushes on
// disp_valid & disp_ready; the link write completes on the cycle wb_req & wb_grant.
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int XLEN  = JUMP_XLEN,
    parameter int TAG_W = JUMP_TAG_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [1:0]       disp_op,
    input  logic [2:0]       disp_cmp_ctrl,
    input  logic [XLEN-1:0]  disp_rs1_val,
    input  logic [XLEN-1:0]  disp_rs2_val,
    input  logic             disp_rs1_rdy,
    input  logic             disp_rs2_rdy,
    input  logic [TAG_W-1:0] disp_rs1_tag,
    input  logic [TAG_W-1:0] disp_rs2_tag,
    input  logic [XLEN-1:0]  disp_imm,
    input  logic [XLEN-1:0]  disp_pc,
    input  logic [TAG_W-1:0] disp_rd_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_data,
    output logic             fu_en,
    output logic             fu_jalr,
    output logic [2:0]       fu_cmp_ctrl,
    output logic [XLEN-1:0]  fu_rs1,
    output logic [XLEN-1:0]  fu_rs2,
    output logic [XLEN-1:0]  fu_imm,
    output logic [XLEN-1:0]  fu_pc,
    input  logic [XLEN-1:0]  fu_pc_jump,
    input  logic [XLEN-1:0]  fu_pc_wb,
    input  logic             fu_cmp_res,
    input  logic             fu_finish,
    output logic             redir_valid,
    output logic [XLEN-1:0]  redir_pc,
    output logic             wb_req,
    output logic [TAG_W-1:0] wb_tag,
    output logic [XLEN-1:0]  wb_data,
    input  logic             wb_grant,
    output state_t           dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               taken_q, taken_d, is_br_q, is_br_d;
    logic [XLEN-1:0]    target_q, target_d, link_q, link_d;
    logic [TAG_W-1:0]   rd_tag_q, rd_tag_d;

    logic               push, pop, flush;
    entry_t             wr_entry;
    logic [DEPTH-1:0]   slot_wr, slot_clr, slot_rdy;
    issue_t             slot_iss [DEPTH];
    issue_t             head_iss;
    logic               head_rdy;

    assign disp_ready = (count_q < FULL) & ~redir_valid;
    assign push       = disp_valid & disp_ready;
    assign flush      = redir_valid;

    // JAL carries no register operands and JALR only rs1, so the rest enter ready.
    always_comb begin
        wr_entry          = '0;
        wr_entry.valid    = 1'b1;
        wr_entry.op       = disp_op;
        wr_entry.cmp_ctrl = disp_cmp_ctrl;
        wr_entry.rs1_val  = disp_rs1_val;
        wr_entry.rs1_rdy  = disp_rs1_rdy | (disp_op == JOP_JAL);
        wr_entry.rs1_tag  = disp_rs1_tag;
        wr_entry.rs2_val  = disp_rs2_val;
        wr_entry.rs2_rdy  = disp_rs2_rdy | (disp_op != JOP_BR);
        wr_entry.rs2_tag  = disp_rs2_tag;
        wr_entry.imm      = disp_imm;
        wr_entry.pc       = disp_pc;
        wr_entry.rd_tag   = disp_rd_tag;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign slot_wr[gi]  = push && (tail_q == PTR_W'(gi));
        assign slot_clr[gi] = flush || (pop && (head_q == PTR_W'(gi)));
        jump_rs_entry u_entry (
            .clk         (clk),
            .rst_n       (rst),
            .wr_en_i     (slot_wr[gi]),
            .wr_entry_i  (wr_entry),
            .clr_i       (slot_clr[gi]),
            .cdb_valid_i (cdb_valid),
            .cdb_tag_i   (cdb_tag),
            .cdb_data_i  (cdb_data),
            .ready_o     (slot_rdy[gi]),
            .issue_o     (slot_iss[gi])
        );
    end

    assign head_iss = slot_iss[head_q];
    assign head_rdy = slot_rdy[head_q];

    // The head stays put until finish, so FU operands are stable for the whole operation.
    assign fu_jalr     = (head_iss.op == JOP_JALR);
    assign fu_cmp_ctrl = head_iss.cmp_ctrl;
    assign fu_rs1      = head_iss.rs1_val;
    assign fu_rs2      = head_iss.rs2_val;
    assign fu_imm      = head_iss.imm;
    assign fu_pc       = head_iss.pc;

    assign redir_valid = (state_q == ST_RESOLVE) & taken_q;
    assign redir_pc    = target_q;
    assign wb_req      = (state_q == ST_WB);
    assign wb_tag      = rd_tag_q;
    assign wb_data     = link_q;
    assign dbg_state   = state_q;

    always_comb begin
        state_d  = state_q;
        fu_en    = 1'b0;
        pop      = 1'b0;
        taken_d  = taken_q;
        is_br_d  = is_br_q;
        target_d = target_q;
        link_d   = link_q;
        rd_tag_d = rd_tag_q;
        unique case (state_q)
            ST_IDLE: begin
                if (head_rdy) begin
                    fu_en   = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (fu_finish) begin
                    pop      = 1'b1;
                    taken_d  = (head_iss.op != JOP_BR) | fu_cmp_res;
                    is_br_d  = (head_iss.op == JOP_BR);
                    target_d = fu_pc_jump;
                    link_d   = fu_pc_wb;
                    rd_tag_d = head_iss.rd_tag;
                    state_d  = ST_RESOLVE;
                end
            end
            ST_RESOLVE: state_d = is_br_q ? ST_IDLE : ST_WB;
            ST_WB:      if (wb_grant) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            taken_q  <= 1'b0;
            is_br_q  <= 1'b0;
            target_q <= '0;
            link_q   <= '0;
            rd_tag_q <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            taken_q  <= taken_d;
            is_br_q  <= is_br_d;
            target_q <= target_d;
            link_q   <= link_d;
            rd_tag_q <= rd_tag_d;
        end
    end

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed bench for jump_ctrl: the bench plays dispatch, CDB, FU_jump and the CDB arbiter.
module tb_jump_ctrl;
    import jump_pkg::*;

    logic        clk, rst;
    logic        disp_valid, disp_ready;
    logic [1:0]  disp_op;
    logic [2:0]  disp_cmp_ctrl;
    logic [31:0] disp_rs1_val, disp_rs2_val;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [2:0]  disp_rs1_tag, disp_rs2_tag;
    logic [31:0] disp_imm, disp_pc;
    logic [2:0]  disp_rd_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        fu_en, fu_jalr;
    logic [2:0]  fu_cmp_ctrl;
    logic [31:0] fu_rs1, fu_rs2, fu_imm, fu_pc;
    logic [31:0] fu_pc_jump, fu_pc_wb;
    logic        fu_cmp_res, fu_finish;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        wb_req;
    logic [2:0]  wb_tag;
    logic [31:0] wb_data;
    logic        wb_grant;
    state_t      dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    jump_ctrl #(.XLEN(32), .TAG_W(3), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_cmp_ctrl(disp_cmp_ctrl), .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rd_tag(disp_rd_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_en(fu_en), .fu_jalr(fu_jalr), .fu_cmp_ctrl(fu_cmp_ctrl),
        .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_imm(fu_imm), .fu_pc(fu_pc),
        .fu_pc_jump(fu_pc_jump), .fu_pc_wb(fu_pc_wb),
        .fu_cmp_res(fu_cmp_res), .fu_finish(fu_finish),
        .redir_valid(redir_valid), .redir_pc(redir_pc),
        .wb_req(wb_req), .wb_tag(wb_tag), .wb_data(wb_data), .wb_grant(wb_grant),
        .dbg_state(dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change 1 time unit after posedge, outputs are sampled on negedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        disp_valid = 1'b0; disp_op = JOP_BR; disp_cmp_ctrl = 3'd0;
        disp_rs1_val = '0; disp_rs2_val = '0; disp_rs1_rdy = 1'b0; disp_rs2_rdy = 1'b0;
        disp_rs1_tag = '0; disp_rs2_tag = '0; disp_imm = '0; disp_pc = '0; disp_rd_tag = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        fu_pc_jump = '0; fu_pc_wb = '0; fu_cmp_res = 1'b0; fu_finish = 1'b0;
        wb_grant = 1'b0;
    endtask

    task automatic set_disp(input logic [1:0] op, input logic [2:0] cmp,
                            input logic [31:0] r1v, input logic r1r, input logic [2:0] r1t,
                            input logic [31:0] r2v, input logic r2r, input logic [2:0] r2t,
                            input logic [31:0] imm, input logic [31:0] pc, input logic [2:0] rd);
        disp_valid = 1'b1; disp_op = op; disp_cmp_ctrl = cmp;
        disp_rs1_val = r1v; disp_rs1_rdy = r1r; disp_rs1_tag = r1t;
        disp_rs2_val = r2v; disp_rs2_rdy = r2r; disp_rs2_tag = r2t;
        disp_imm = imm; disp_pc = pc; disp_rd_tag = rd;
    endtask

    task automatic fu_done(input logic cmp_res, input logic [31:0] jmp, input logic [31:0] link);
        fu_finish = 1'b1; fu_cmp_res = cmp_res; fu_pc_jump = jmp; fu_pc_wb = link;
    endtask

    task automatic fu_clear();
        fu_finish = 1'b0; fu_cmp_res = 1'b0; fu_pc_jump = '0; fu_pc_wb = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b0;
        repeat (2) sample();
        n_cmp++; if (fu_en !== 1'b0) begin n_err++; $display("FAIL rst_fu_en: got %h want 0", fu_en); end
        n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("FAIL rst_redir_valid: got %h want 0", redir_valid); end
        n_cmp++; if (redir_pc !== 32'h0) begin n_err++; $display("FAIL rst_redir_pc: got %h want 0", redir_pc); end
        n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL rst_wb_req: got %h want 0", wb_req); end
        n_cmp++; if (wb_tag !== 3'h0) begin n_err++; $display("FAIL rst_wb_tag: got %h want 0", wb_tag); end
        n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("FAIL rst_wb_data: got %h want 0", wb_data); end
        n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL rst_disp_ready: got %h want 1", disp_ready); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_br_taken();
        set_disp(JOP_BR, 3'b000, 32'd5, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'h20, 32'h100, 3'd0);
        sample();
        n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL beq_disp_ready: got %h want 1", disp_ready); end
        step();
        disp_valid = 1'b0;
        sample();
        n_cmp++; if (fu_en !== 1'b1) begin n_err++; $display("FAIL beq_fu_en: got %h want 1", fu_en); end
        n_cmp++; if (fu_rs1 !== 32'd5) begin n_err++; $display("FAIL beq_fu_rs1: got %h want 5", fu_rs1); end
        n_cmp++; if (fu_rs2 !== 32'd5) begin n_err++; $display("FAIL beq_fu_rs2: got %h want 5", fu_rs2); end
        n_cmp++; if (fu_imm !== 32'h20) begin n_err++; $display("FAIL beq_fu_imm: got %h want 20", fu_imm); end
        n_cmp++; if (fu_pc !== 32'h100) begin n_err++; $display("FAIL beq_fu_pc: got %h want 100", fu_pc); end
        n_cmp++; if (fu_jalr !== 1'b0) begin n_err++; $display("FAIL beq_fu_jalr: got %h want 0", fu_jalr); end
        n_cmp++; if (fu_cmp_ctrl !== 3'b000) begin n_err++; $display("FAIL beq_fu_cmp: got %h want 0", fu_cmp_ctrl); end
        step();
        fu_done(1'b1, 32'h120, 32'h104);
        sample();
        n_cmp++; if (fu_en !== 1'b0) begin n_err++; $display("FAIL beq_fu_en_pulse: got %h want 0", fu_en); end
        n_cmp++; if (fu_pc !== 32'h100) begin n_err++; $display("FAIL beq_fu_pc_hold: got %h want 100", fu_pc); end
        step();
        fu_clear();
        sample();
        n_cmp++; if (redir_valid !== 1'b1) begin n_err++; $display("FAIL beq_redir_valid: got %h want 1", redir_valid); end
        n_cmp++; if (redir_pc !== 32'h120) begin n_err++; $display("FAIL beq_redir_pc: got %h want 120", redir_pc); end
        n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL beq_wb_req: got %h want 0", wb_req); end
        step();
        sample();
        n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("FAIL beq_redir_drop: got %h want 0", redir_valid); end
        n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL beq_wb_req_t3: got %h want 0", wb_req); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL beq_state_t3: got %0d want %0d", dbg_state, ST_IDLE); end
        step();
    endtask

    task automatic test_br_not_taken();
        set_disp(JOP_BR, 3'b001, 32'd5, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'h20, 32'h100, 3'd0);
        step();
        disp_valid = 1'b0;
        sample();
        n_cmp++; if (fu_en !== 1'b1) begin n_err++; $display("FAIL bne_fu_en: got %h want 1", fu_en); end
        n_cmp++; if (fu_cmp_ctrl !== 3'b001) begin n_err++; $display("FAIL bne_fu_cmp: got %h want 1", fu_cmp_ctrl); end
        step();
        fu_done(1'b0, 32'h120, 32'h104);
        step();
        fu_clear();
        sample();
        n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("FAIL bne_redir_valid: got %h want 0", redir_valid); end
        n_cmp++; if (dbg_state !== ST_RESOLVE) begin n_err++; $display("FAIL bne_state_t2: got %0d want %0d", dbg_state, ST_RESOLVE); end
        step();
        sample();
        n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL bne_wb_req: got %h want 0", wb_req); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL bne_state_t3: got %0d want %0d", dbg_state, ST_IDLE); end
        step();
    endtask

    task automatic test_jalr_cdb();
        set_disp(JOP_JALR, 3'b000, 32'h0, 1'b0, 3'd3, 32'h0, 1'b0, 3'd4, 32'h8, 32'h200, 3'd5);
        sample();
        n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL jalr_disp_ready: got %h want 1", disp_ready); end
        step();
        disp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            n_cmp++; if (fu_en !== 1'b0) begin n_err++; $display("FAIL jalr_wait_%0d: got %h want 0", i, fu_en); end
            step();
        end
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'h400;
        sample();
        n_cmp++; if (fu_en !== 1'b0) begin n_err++; $display("FAIL jalr_cdb_same_cycle: got %h want 0", fu_en); end
        step();
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        sample();
        n_cmp++; if (fu_en !== 1'b1) begin n_err++; $display("FAIL jalr_fu_en: got %h want 1", fu_en); end
        n_cmp++; if (fu_rs1 !== 32'h400) begin n_err++; $display("FAIL jalr_fu_rs1: got %h want 400", fu_rs1); end
        n_cmp++; if (fu_jalr !== 1'b1) begin n_err++; $display("FAIL jalr_fu_jalr: got %h want 1", fu_jalr); end
        n_cmp++; if (fu_imm !== 32'h8) begin n_err++; $display("FAIL jalr_fu_imm: got %h want 8", fu_imm); end
        n_cmp++; if (fu_pc !== 32'h200) begin n_err++; $display("FAIL jalr_fu_pc: got %h want 200", fu_pc); end
        step();
        fu_done(1'b0, 32'h408, 32'h204);
        step();
        fu_clear();
        sample();
        n_cmp++; if (redir_valid !== 1'b1) begin n_err++; $display("FAIL jalr_redir_valid: got %h want 1", redir_valid); end
        n_cmp++; if (redir_pc !== 32'h408) begin n_err++; $display("FAIL jalr_redir_pc: got %h want 408", redir_pc); end
        n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL jalr_wb_early: got %h want 0", wb_req); end
        step();
        wb_grant = 1'b1;
        sample();
        n_cmp++; if (wb_req !== 1'b1) begin n_err++; $display("FAIL jalr_wb_req: got %h want 1", wb_req); end
        n_cmp++; if (wb_tag !== 3'd5) begin n_err++; $display("FAIL jalr_wb_tag: got %h want 5", wb_tag); end
        n_cmp++; if (wb_data !== 32'h204) begin n_err++; $display("FAIL jalr_wb_data: got %h want 204", wb_data); end
        step();
        wb_grant = 1'b0;
        sample();
        n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL jalr_wb_drop: got %h want 0", wb_req); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL jalr_state_idle: got %0d want %0d", dbg_state, ST_IDLE); end
        step();
    endtask

    task automatic test_wb_stall();
        set_disp(JOP_JAL, 3'b000, 32'h0, 1'b0, 3'd1, 32'h0, 1'b0, 3'd2, 32'h40, 32'h300, 3'd6);
        step();
        disp_valid = 1'b0;
        sample();
        n_cmp++; if (fu_en !== 1'b1) begin n_err++; $display("FAIL jal_fu_en: got %h want 1", fu_en); end
        n_cmp++; if (fu_pc !== 32'h300) begin n_err++; $display("FAIL jal_fu_pc: got %h want 300", fu_pc); end
        step();
        fu_done(1'b0, 32'h340, 32'h304);
        step();
        fu_clear();
        sample();
        n_cmp++; if (redir_pc !== 32'h340) begin n_err++; $display("FAIL jal_redir_pc: got %h want 340", redir_pc); end
        step();
        for (int i = 0; i < 3; i++) begin
            sample();
            n_cmp++; if (wb_req !== 1'b1) begin n_err++; $display("FAIL stall_wb_req_%0d: got %h want 1", i, wb_req); end
            n_cmp++; if (wb_tag !== 3'd6) begin n_err++; $display("FAIL stall_wb_tag_%0d: got %h want 6", i, wb_tag); end
            n_cmp++; if (wb_data !== 32'h304) begin n_err++; $display("FAIL stall_wb_data_%0d: got %h want 304", i, wb_data); end
            step();
        end
        wb_grant = 1'b1;
        sample();
        n_cmp++; if (wb_req !== 1'b1) begin n_err++; $display("FAIL stall_wb_grant_cycle: got %h want 1", wb_req); end
        step();
        wb_grant = 1'b0;
        sample();
        n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL stall_wb_drop: got %h want 0", wb_req); end
        step();
    endtask

    task automatic test_flush();
        set_disp(JOP_BR, 3'b000, 32'd7, 1'b1, 3'd0, 32'd7, 1'b1, 3'd0, 32'h40, 32'h700, 3'd0);
        step();
        set_disp(JOP_BR, 3'b000, 32'd1, 1'b1, 3'd0, 32'd2, 1'b1, 3'd0, 32'h10, 32'h800, 3'd0);
        sample();
        n_cmp++; if (fu_en !== 1'b1) begin n_err++; $display("FAIL flush_fu_en_a: got %h want 1", fu_en); end
        n_cmp++; if (fu_pc !== 32'h700) begin n_err++; $display("FAIL flush_fu_pc_a: got %h want 700", fu_pc); end
        n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL flush_disp_ready_b: got %h want 1", disp_ready); end
        step();
        disp_valid = 1'b0;
        fu_done(1'b1, 32'h740, 32'h704);
        step();
        fu_clear();
        set_disp(JOP_BR, 3'b000, 32'd3, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 32'h0, 32'h900, 3'd0);
        sample();
        n_cmp++; if (redir_valid !== 1'b1) begin n_err++; $display("FAIL flush_redir_valid: got %h want 1", redir_valid); end
        n_cmp++; if (redir_pc !== 32'h740) begin n_err++; $display("FAIL flush_redir_pc: got %h want 740", redir_pc); end
        n_cmp++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL flush_disp_ready_redir: got %h want 0", disp_ready); end
        step();
        disp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sample();
            n_cmp++; if (fu_en !== 1'b0) begin n_err++; $display("FAIL flush_no_issue_%0d: got %h want 0", i, fu_en); end
            step();
        end
    endtask

    task automatic test_full_reset();
        set_disp(JOP_BR, 3'b000, 32'h0, 1'b0, 3'd1, 32'h0, 1'b0, 3'd1, 32'h4, 32'h500, 3'd0);
        sample();
        n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL full_push0: got %h want 1", disp_ready); end
        step();
        set_disp(JOP_BR, 3'b000, 32'h0, 1'b0, 3'd2, 32'h0, 1'b0, 3'd2, 32'h4, 32'h600, 3'd0);
        sample();
        n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL full_push1: got %h want 1", disp_ready); end
        step();
        set_disp(JOP_BR, 3'b000, 32'hdead, 1'b1, 3'd0, 32'hdead, 1'b1, 3'd0, 32'h0, 32'ha00, 3'd0);
        sample();
        n_cmp++; if (disp_ready !== 1'b0) begin n_err++; $display("FAIL full_disp_ready: got %h want 0", disp_ready); end
        n_cmp++; if (fu_en !== 1'b0) begin n_err++; $display("FAIL full_no_issue: got %h want 0", fu_en); end
        step();
        disp_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'h11;
        step();
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
        sample();
        n_cmp++; if (fu_en !== 1'b1) begin n_err++; $display("FAIL full_fu_en: got %h want 1", fu_en); end
        n_cmp++; if (fu_pc !== 32'h500) begin n_err++; $display("FAIL full_fu_pc: got %h want 500", fu_pc); end
        n_cmp++; if (fu_rs1 !== 32'h11) begin n_err++; $display("FAIL full_fu_rs1: got %h want 11", fu_rs1); end
        n_cmp++; if (fu_rs2 !== 32'h11) begin n_err++; $display("FAIL full_fu_rs2: got %h want 11", fu_rs2); end
        step();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if (fu_en !== 1'b0) begin n_err++; $display("FAIL arst_fu_en: got %h want 0", fu_en); end
        n_cmp++; if (fu_pc !== 32'h0) begin n_err++; $display("FAIL arst_fu_pc: got %h want 0", fu_pc); end
        n_cmp++; if (fu_rs1 !== 32'h0) begin n_err++; $display("FAIL arst_fu_rs1: got %h want 0", fu_rs1); end
        n_cmp++; if (redir_valid !== 1'b0) begin n_err++; $display("FAIL arst_redir_valid: got %h want 0", redir_valid); end
        n_cmp++; if (redir_pc !== 32'h0) begin n_err++; $display("FAIL arst_redir_pc: got %h want 0", redir_pc); end
        n_cmp++; if (wb_req !== 1'b0) begin n_err++; $display("FAIL arst_wb_req: got %h want 0", wb_req); end
        n_cmp++; if (wb_tag !== 3'h0) begin n_err++; $display("FAIL arst_wb_tag: got %h want 0", wb_tag); end
        n_cmp++; if (wb_data !== 32'h0) begin n_err++; $display("FAIL arst_wb_data: got %h want 0", wb_data); end
        n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL arst_state: got %0d want %0d", dbg_state, ST_IDLE); end
        sample();
        n_cmp++; if (disp_ready !== 1'b1) begin n_err++; $display("FAIL arst_disp_ready: got %h want 1", disp_ready); end
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_br_taken();
        test_br_not_taken();
        test_jalr_cdb();
        test_wb_stall();
        test_flush();
        test_full_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
